seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for the DE2 hex displays. Two requesters share one bank of up to eight 7-segment digits through a round-robin arbiter with a one-deep pending buffer. Committed values are scanned digit by digit through a single internal SEG7 decoder instance. Updates are frame-aligned so a displayed value never tears mid-scan.

## Interface
- NUM_DIGITS, 8, number of scanned digits, legal 1..8
- DIV_CYCLES, 50000, iCLK cycles per digit slot, legal ≥ 2
- iCLK  in  1  system clock; all state on rising edge
- iRST_N  in  1  reset, asynchronous assert, active-low
- iREQ_A  in  1  requester A wants to load iDATA_A
- iDATA_A  in  32  value for A; nibble k drives digit k
- oGNT_A  out  1  one-cycle grant pulse to A
- iREQ_B  in  1  requester B wants to load iDATA_B
- iDATA_B  in  32  value for B
- oGNT_B  out  1  one-cycle grant pulse to B
- iBLANK  in  1  force whole display dark
- oSEGMENT  out  7  active-low segments {g..a} of the current digit
- oDIG_SEL_N  out  NUM_DIGITS  active-low one-hot digit enable
- oDIGIT_IDX  out  3  index of the digit currently driven
- oPENDING  out  1  a granted value is waiting for a frame boundary

## Operation
- Reset values: div counter 0, idx 0, display reg 0, pending reg 0, state IDLE, priority pointer A, oGNT_A/B 0, oPENDING 0, oSEGMENT 7'h7F, oDIG_SEL_N all ones, oDIGIT_IDX 0.
- Scan: div counts 0..DIV_CYCLES-1 and wraps. Tick occurs when div == DIV_CYCLES-1. On tick, idx = (idx+1) mod NUM_DIGITS. A frame boundary is a tick with idx == NUM_DIGITS-1.
- Decode: nibble display[4*idx+3:4*idx] passes through SEG7. oSEGMENT, oDIG_SEL_N = ~(1<<idx), and oDIGIT_IDX are registered together.
- iBLANK=1: oSEGMENT 7'h7F and oDIG_SEL_N all ones on the next edge. Scan counters keep running.
- FSM IDLE: if any iREQ is high, grant one requester. With both requesting, grant the one at the pointer, then move the pointer to the other requester. With one requesting, grant it and move the pointer to the other. Assert oGNT_x for that cycle, capture iDATA_x into pending at the edge ending that cycle, and go to PEND.
- FSM PEND: oPENDING=1 and no grants. On a frame boundary, copy pending to display and return to IDLE. The new value is first driven with digit 0.
- Requester holds iREQ and iDATA stable until it sees oGNT, then drops iREQ. iREQ still high in a later IDLE cycle is a new request.
- Width rules: only nibbles 0..NUM_DIGITS-1 are used. Upper data bits are ignored.

## Timing
- Grant: iREQ sampled high in IDLE gives oGNT in that same cycle (combinational from registered state), with pending loaded at the next edge.
- Commit: at the frame-boundary edge in PEND. The earliest new grant comes in the cycle after that edge, so commit and grant never occur on one edge.
- Scan latency: segment, select and idx change on the same edge, one edge after the tick.
- Reset mid-operation (asynchronous): all state returns to reset values immediately. A pending value is discarded, no grant is issued, and outputs go dark.
- Back-to-back requests: at most one value per frame is accepted. The waiting requester keeps iREQ high until granted.

## Configuration
- SEG7_SCAN_LZB_EN defined: leading-zero blanking. A digit k>0 whose nibble and all higher used nibbles are 0 drives oSEGMENT 7'h7F, with its select still asserted. Digit 0 is never blanked.
- Undefined: every digit shows its nibble, including 0 (7'b1000000).

## Test plan
- Reset release with DIV_CYCLES=4, NUM_DIGITS=8: idx steps 0..7 every 4 cycles. oDIG_SEL_N walks 8'hFE..8'h7F. Every oSEGMENT is 7'b1000000 (LZB off) or 7'h7F on digits 1..7 (LZB on).
- A alone loads 32'h0000_00A5 in IDLE: one-cycle oGNT_A and oPENDING=1. At the next frame boundary oPENDING drops. Digit 0 then shows 7'b0010010 and digit 1 shows 7'b0001000.
- A and B request simultaneously twice: first grant goes to A, second (after commit) goes to B. Exactly one oGNT pulse per frame.
- Request during PEND: no grant until the cycle after commit. Data captured is the held value.
- iBLANK pulsed mid-frame: outputs are dark on the next edge, and idx continues counting.
- iRST_N asserted while PEND with 32'h1234_5678: pending is discarded and outputs go dark immediately. After release, the display shows 0s.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for up to eight 7-segment
// digits. Two requesters share the display through a round-robin arbiter with
// a one-deep pending buffer; new values are committed only at frame boundaries.
// Optional build macro: SEG7_SCAN_LZB_EN enables leading-zero blanking.

// Hex nibble to active-low {g..a} segment pattern.
module seg7_dec (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    // Pure lookup; every nibble value is listed so no state is implied.
    always_comb begin
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_CYCLES = 50000
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iREQ_A,
    input  logic [31:0]           iDATA_A,
    output logic                  oGNT_A,
    input  logic                  iREQ_B,
    input  logic [31:0]           iDATA_B,
    output logic                  oGNT_B,
    input  logic                  iBLANK,
    output logic [6:0]            oSEGMENT,
    output logic [NUM_DIGITS-1:0] oDIG_SEL_N,
    output logic [2:0]            oDIGIT_IDX,
    output logic                  oPENDING
);
    localparam int                DATA_W   = 4 * NUM_DIGITS;
    localparam int                DIV_W    = $clog2(DIV_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_CYCLES - 1);
    localparam logic [2:0]        IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]        SEG_DARK = 7'h7F;

    typedef enum logic { S_IDLE, S_PEND } state_e;
    typedef enum logic { PTR_A, PTR_B }   ptr_e;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [2:0]            idx_q, idx_d;
    state_e                state_q, state_d;
    ptr_e                  ptr_q, ptr_d;
    logic [DATA_W-1:0]     pending_q, pending_d;
    logic [DATA_W-1:0]     display_q, display_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [2:0]            didx_q, didx_d;

    logic       tick, frame_end;
    logic       gnt_a, gnt_b;
    logic [3:0] nibble;
    logic [6:0] seg_dec;
    logic       lzb_blank;
`ifdef SEG7_SCAN_LZB_EN
    logic       run_zero;
`endif

    // Only the low DATA_W bits of each request word reach the display.
    logic unused_data;
    assign unused_data = ^{iDATA_A, iDATA_B};

    // Digit-slot divider and digit index; a frame ends on the last digit's tick.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tick      = (div_q == DIV_LAST);
        frame_end = tick && (idx_q == IDX_LAST);
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Round-robin arbiter and pending/commit FSM; grants are combinational off registered state.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        display_d = display_q;
        if (state_q == S_IDLE) begin
            if (iREQ_A && iREQ_B) begin
                gnt_a = (ptr_q == PTR_A);
                gnt_b = (ptr_q == PTR_B);
            end else begin
                gnt_a = iREQ_A;
                gnt_b = iREQ_B;
            end
            if (gnt_a) begin
                pending_d = iDATA_A[DATA_W-1:0];
                ptr_d     = PTR_B;
                state_d   = S_PEND;
            end else if (gnt_b) begin
                pending_d = iDATA_B[DATA_W-1:0];
                ptr_d     = PTR_A;
                state_d   = S_PEND;
            end
        end else if (frame_end) begin
            // Commit on the frame edge so the new value starts with digit 0.
            display_d = pending_q;
            state_d   = S_IDLE;
        end
    end

    // Select the current digit's nibble and, optionally, its leading-zero blank.
    always_comb begin
        nibble    = 4'h0;
        lzb_blank = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
        run_zero  = 1'b1;
`endif
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef SEG7_SCAN_LZB_EN
            run_zero = run_zero && (display_q[4*k +: 4] == 4'h0);
`endif
            if (idx_q == 3'(k)) begin
                nibble = display_q[4*k +: 4];
`ifdef SEG7_SCAN_LZB_EN
                lzb_blank = run_zero && (k != 0);
`endif
            end
        end
    end

    seg7_dec u_seg7_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Next values of the registered display outputs; blanking overrides everything.
    always_comb begin
        seg_d  = lzb_blank ? SEG_DARK : seg_dec;
        sel_d  = '1;
        didx_d = idx_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_d[k] = (idx_q != 3'(k));
        end
        if (iBLANK) begin
            seg_d = SEG_DARK;
            sel_d = '1;
        end
    end

    // All state, including the data buffers, returns to a known dark/empty state on reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_q     <= '0;
            idx_q     <= 3'd0;
            state_q   <= S_IDLE;
            ptr_q     <= PTR_A;
            pending_q <= '0;
            display_q <= '0;
            seg_q     <= SEG_DARK;
            sel_q     <= '1;
            didx_q    <= 3'd0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            div_q     <= div_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            display_q <= display_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
            didx_q    <= didx_d;
        end
    end

    assign oGNT_A     = gnt_a;
    assign oGNT_B     = gnt_b;
    assign oSEGMENT   = seg_q;
    assign oDIG_SEL_N = sel_q;
    assign oDIGIT_IDX = didx_q;
    assign oPENDING   = (state_q == S_PEND);

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV_CYCLES=4, NUM_DIGITS=8.
// Honours SEG7_SCAN_LZB_EN when the design is built with it.
module tb_seg7_scan_ctrl;
    localparam int ND  = 8;
    localparam int DIV = 4;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] DARK  = 7'h7F;
`ifdef SEG7_SCAN_LZB_EN
    localparam logic [6:0] HI_ZERO = 7'h7F;
`else
    localparam logic [6:0] HI_ZERO = 7'b1000000;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] idx;
        logic [7:0] sel;
        logic [6:0] seg;
    } scan_vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a, req_b, blank;
    logic [31:0]   data_a, data_b;
    logic          gnt_a, gnt_b, pending;
    logic [6:0]    seg;
    logic [ND-1:0] sel_n;
    logic [2:0]    didx;

    int errors = 0;
    int checks = 0;
    int cyc;
    int gnt_cnt;
    scan_vec_t scan_tbl [8];

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .DIV_CYCLES (DIV)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iREQ_A     (req_a),
        .iDATA_A    (data_a),
        .oGNT_A     (gnt_a),
        .iREQ_B     (req_b),
        .iDATA_B    (data_b),
        .oGNT_B     (gnt_b),
        .iBLANK     (blank),
        .oSEGMENT   (seg),
        .oDIG_SEL_N (sel_n),
        .oDIGIT_IDX (didx),
        .oPENDING   (pending)
    );

    always #5 clk = ~clk;

    // Edges since reset release: after edge n the bench sees cyc == n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Grants seen at clock edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              gnt_cnt <= 0;
        else if (gnt_a || gnt_b) gnt_cnt <= gnt_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached %0d target %0d", cyc, n);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] e_idx,
                             input logic [7:0] e_sel, input logic [6:0] e_seg);
        check({name, "_idx"}, 32'(didx), 32'(e_idx));
        check({name, "_sel"}, 32'(sel_n), 32'(e_sel));
        check({name, "_seg"}, 32'(seg), 32'(e_seg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_a  = 1'b0;
        req_b  = 1'b0;
        blank  = 1'b0;
        data_a = '0;
        data_b = '0;

        // Display is all zeros after reset; output slot k is visible from edge 4k+1.
        scan_tbl[0] = '{1,  3'd0, 8'hFE, SEG_0};
        scan_tbl[1] = '{5,  3'd1, 8'hFD, HI_ZERO};
        scan_tbl[2] = '{9,  3'd2, 8'hFB, HI_ZERO};
        scan_tbl[3] = '{13, 3'd3, 8'hF7, HI_ZERO};
        scan_tbl[4] = '{17, 3'd4, 8'hEF, HI_ZERO};
        scan_tbl[5] = '{21, 3'd5, 8'hDF, HI_ZERO};
        scan_tbl[6] = '{25, 3'd6, 8'hBF, HI_ZERO};
        scan_tbl[7] = '{29, 3'd7, 8'h7F, HI_ZERO};

        // Reset state.
        @(negedge clk);
        check_out("reset", 3'd0, 8'hFF, DARK);
        check("reset_pend", 32'(pending), 32'd0);
        check("reset_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scan walk over the first frame.
        foreach (scan_tbl[i]) begin
            wait_cyc(scan_tbl[i].cyc);
            check_out($sformatf("scan%0d", i), scan_tbl[i].idx, scan_tbl[i].sel, scan_tbl[i].seg);
        end

        // Simultaneous requests: A wins first, B waits through the frame.
        wait_cyc(30);
        req_a = 1'b1; data_a = 32'h0000_1111;
        req_b = 1'b1; data_b = 32'h0000_2222;
        #1;
        check("both_gnt_a", 32'(gnt_a), 32'd1);
        check("both_gnt_b", 32'(gnt_b), 32'd0);
        wait_cyc(31);
        check("a_pend", 32'(pending), 32'd1);
        check("pend_no_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
        req_a = 1'b0;
        wait_cyc(32);
        check("commit1_pend", 32'(pending), 32'd0);
        check("b_gnt_after_commit", 32'(gnt_b), 32'd1);
        check("b_gnt_a_low", 32'(gnt_a), 32'd0);
        check("frame1_gnts", 32'(gnt_cnt), 32'd1);
        wait_cyc(33);
        check("b_pend", 32'(pending), 32'd1);
        check("b_gnt_pulse", 32'(gnt_b), 32'd0);
        req_b = 1'b0; data_b = 32'h9999_9999;
        check_out("a_dig0", 3'd0, 8'hFE, SEG_1);
        wait_cyc(45);
        check_out("a_dig3", 3'd3, 8'hF7, SEG_1);
        wait_cyc(49);
        check_out("a_dig4", 3'd4, 8'hEF, HI_ZERO);
        wait_cyc(63);
        check("b_pend_hold", 32'(pending), 32'd1);
        wait_cyc(64);
        check("commit2_pend", 32'(pending), 32'd0);
        check("frame2_gnts", 32'(gnt_cnt), 32'd2);
        wait_cyc(65);
        check_out("b_dig0", 3'd0, 8'hFE, SEG_2);

        // A alone loads 0xA5.
        wait_cyc(66);
        req_a = 1'b1; data_a = 32'h0000_00A5;
        #1;
        check("a5_gnt_a", 32'(gnt_a), 32'd1);
        check("a5_gnt_b", 32'(gnt_b), 32'd0);
        check("a5_idle", 32'(pending), 32'd0);
        wait_cyc(67);
        check("a5_gnt_pulse", 32'(gnt_a), 32'd0);
        check("a5_pend", 32'(pending), 32'd1);
        req_a = 1'b0; data_a = 32'hFFFF_FFFF;
        wait_cyc(95);
        check("a5_pend_hold", 32'(pending), 32'd1);
        wait_cyc(96);
        check("a5_commit", 32'(pending), 32'd0);
        check("frame3_gnts", 32'(gnt_cnt), 32'd3);
        wait_cyc(97);
        check_out("a5_dig0", 3'd0, 8'hFE, SEG_5);
        wait_cyc(101);
        check_out("a5_dig1", 3'd1, 8'hFD, SEG_A);
        wait_cyc(105);
        check_out("a5_dig2", 3'd2, 8'hFB, HI_ZERO);

        // Blank mid-frame: dark on the next edge, scan keeps counting.
        wait_cyc(106);
        blank = 1'b1;
        wait_cyc(107);
        check_out("blank_on", 3'd2, 8'hFF, DARK);
        wait_cyc(109);
        check_out("blank_count", 3'd3, 8'hFF, DARK);
        blank = 1'b0;
        wait_cyc(110);
        check_out("blank_off", 3'd3, 8'hF7, HI_ZERO);

        // Reset while a value is pending.
        wait_cyc(112);
        req_a = 1'b1; data_a = 32'h1234_5678;
        #1;
        check("rst_case_gnt", 32'(gnt_a), 32'd1);
        wait_cyc(113);
        req_a = 1'b0;
        check("rst_case_pend", 32'(pending), 32'd1);
        wait_cyc(120);
        rst_n = 1'b0;
        #1;
        check_out("midrst", 3'd0, 8'hFF, DARK);
        check("midrst_pend", 32'(pending), 32'd0);
        check("midrst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        check_out("post_dig0", 3'd0, 8'hFE, SEG_0);
        check("post_pend", 32'(pending), 32'd0);
        wait_cyc(5);
        check_out("post_dig1", 3'd1, 8'hFD, HI_ZERO);
        wait_cyc(33);
        check_out("post_f2_dig0", 3'd0, 8'hFE, SEG_0);
        wait_cyc(37);
        check_out("post_f2_dig1", 3'd1, 8'hFD, HI_ZERO);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
